led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator for board bring-up and status display. It drives a WIDTH-bit LED bank from one of four modes: binary count, Gray count, 32-bit LFSR, and bouncing single-bit scanner. All patterns advance on a common prescaled tick. A debounced push-button cycles through the modes. It replaces hard-wired two-pattern LED demos and sits directly between the board pins and the top level.

## Interface
- WIDTH, 8: LED count; legal range 2..32.
- PRESCALE_BITS, 22: pattern advances once every 2^PRESCALE_BITS clocks; minimum 1.
- DEBOUNCE_BITS, 16: button must be stable for 2^DEBOUNCE_BITS clocks; minimum 1.
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  1  raw, asynchronous mode button, active-high.
- led  out  WIDTH  registered LED pattern, bit 0 = LED1.
- mode  out  2  current mode: 0 binary, 1 Gray, 2 LFSR, 3 bounce.
- tick  out  1  registered one-cycle strobe, high once per prescale period.

## Operation
- **Reset (async, all state):**
  - led=0, mode=0, tick=0.
  - Prescaler=0, step=0, lfsr=32'h0001_0000, pos=one-hot bit 0, dir=up.
  - Sync flops=0, debounce stable=0, debounce counter=0.
- **Prescaler:** PRESCALE_BITS counter, +1 every clock, wraps. tick <= (prescaler == all-ones).
- **Generators:** all four run continuously regardless of mode and advance on every clock edge where tick=1. A mode switch therefore shows the current state of the chosen generator, not a restarted one.
  - **step:** WIDTH-bit, +1, wraps from all-ones to 0.
  - **Gray value:** step ^ (step >> 1).
  - **lfsr (Galois, right-shift):** lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 0). The state can never reach 0.
  - **Bounce:** pos is one-hot, dir is 1 bit.
    - dir=up: pos shifts left; at bit WIDTH-1 it flips dir to down and moves to bit WIDTH-2.
    - dir=down: pos shifts right; at bit 0 it flips dir to up and moves to bit 1.
    - The end bits are shown once per sweep.
- **Output mux (registered every clock):**
  - mode 0: led <= step.
  - mode 1: led <= Gray value.
  - mode 2: led <= lfsr[WIDTH-1:0].
  - mode 3: led <= pos.
- **Button path:**
  - Two-flop synchroniser s1 -> s2.
  - Debounce counter (DEBOUNCE_BITS wide) is cleared whenever s2 == stable.
  - While s2 != stable, the counter increments each clock.
  - On an edge where the counter is all-ones and s2 != stable: stable <= s2 and the counter clears.
  - On the same edge, if s2=1 (a rising stable edge), mode <= mode+1, wrapping 3 -> 0.
  - Falling stable edges do not change mode.
  - Holding the button produces exactly one increment.

## Timing
- **Edge numbering:** edge 1 is the first rising clk edge with rst low.
- **tick:** high in the cycle after edges 2^P, 2·2^P, … (P = PRESCALE_BITS). It is never high for two consecutive cycles when P >= 1.
- **Pattern latency:** generators update at edge n·2^P+1. led shows the new value after edge n·2^P+2.
- **Mode change latency:** if btn is high at edge k and stays high, mode increments at edge k+2^DEBOUNCE_BITS+1. led reflects the new mode after the following edge.
- **Glitch rejection:** an s2 pulse shorter than 2^DEBOUNCE_BITS cycles never changes stable or mode.
- **Reset mid-operation:** rst asserted at any time forces all outputs to their reset values without waiting for clk. Operation resumes from the reset state at edge 1 after release.
- **Simultaneous events:** a mode change on a tick edge is legal. The generators advance and the mux uses the new mode on the next edge.

## Test plan
Bench parameters for all scenarios: WIDTH=4, PRESCALE_BITS=2, DEBOUNCE_BITS=2.

1. **Reset:** assert rst between clock edges mid-run -> led=0000, mode=0, tick=0 immediately. After release, tick is first high after edge 4 and repeats every 4 cycles.
2. **Binary:** mode 0 -> successive led values after each advance are 1, 2, …, 15, then 0 (wrap).
3. **Debounce:**
   - btn high for 3 cycles -> mode stays 0.
   - btn held high from edge k -> mode=1 at edge k+5.
   - Holding btn for 100 cycles gives no further increment.
   - Four separate presses give modes 1, 2, 3, 0.
4. **Gray:** reset, then select mode 1. After step reaches 0..5, led = 0000, 0001, 0011, 0010, 0110, 0111.
5. **LFSR:** mode 2 from reset.
   - led=0000 for advances 1–12.
   - Advances 13–16 give 1000, 0100, 0010, 0001.
   - Advance 17 gives 0011.
6. **Bounce:** mode 3 from reset -> led = 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 on consecutive advances.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// LED pattern generator pin bundle: raw button in, LED bank, mode and tick out.
interface led_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic             btn;
    logic [WIDTH-1:0] led;
    logic [1:0]       mode;
    logic             tick;

    // Board / test side: drives the button, observes the display.
    modport master (
        output btn,
        input  led,
        input  mode,
        input  tick
    );

    // Generator side.
    modport slave (
        input  btn,
        output led,
        output mode,
        output tick
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary, Gray, 32-bit Galois LFSR and bouncing scanner,
// all advancing on a shared prescaled tick, with a debounced mode-cycle button.
//
// Scanner direction:
//   state    | meaning
//   DIR_UP   | lit bit moving toward LED WIDTH
//   DIR_DOWN | lit bit moving toward LED1
module led_pattern_gen #(
    parameter int WIDTH         = 8,
    parameter int PRESCALE_BITS = 22,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_gen_if.slave   bus
);
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [31:0] LFSR_SEED = 32'h0001_0000;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic                     tick_q, tick_d;
    logic [WIDTH-1:0]         step_q, step_d;
    logic [31:0]              lfsr_q, lfsr_d;
    logic [WIDTH-1:0]         pos_q, pos_d;
    dir_e                     dir_q, dir_d;
    logic [WIDTH-1:0]         led_q, led_d;
    logic [1:0]               mode_q, mode_d;
    logic                     s1_q, s1_d;
    logic                     s2_q, s2_d;
    logic                     stable_q, stable_d;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;

    // Next-state for prescaler, generators, button path and the output mux.
    always_comb begin
        presc_d  = presc_q + PRESCALE_BITS'(1);
        tick_d   = (presc_q == '1);
        step_d   = step_q;
        lfsr_d   = lfsr_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        s1_d     = bus.btn;
        s2_d     = s1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        led_d    = led_q;

        // Generators free-run so a mode switch reveals their live state.
        if (tick_q) begin
            step_d = step_q + WIDTH'(1);
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
            if (dir_q == DIR_UP) begin
                if (pos_q[WIDTH-1]) begin
                    dir_d = DIR_DOWN;
                    pos_d = pos_q >> 1;
                end else begin
                    pos_d = pos_q << 1;
                end
            end else begin
                if (pos_q[0]) begin
                    dir_d = DIR_UP;
                    pos_d = pos_q << 1;
                end else begin
                    pos_d = pos_q >> 1;
                end
            end
        end

        // Only a level held for the full debounce window is accepted.
        if (s2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == '1) begin
            stable_d = s2_q;
            db_cnt_d = '0;
            if (s2_q) begin
                mode_d = mode_q + 2'd1;
            end
        end else begin
            db_cnt_d = db_cnt_q + DEBOUNCE_BITS'(1);
        end

        case (mode_q)
            2'd0:    led_d = step_q;
            2'd1:    led_d = step_q ^ (step_q >> 1);
            2'd2:    led_d = lfsr_q[WIDTH-1:0];
            default: led_d = pos_q;
        endcase
    end

    // State register; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            step_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            pos_q    <= WIDTH'(1);
            dir_q    <= DIR_UP;
            led_q    <= '0;
            mode_q   <= 2'd0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            step_q   <= step_d;
            lfsr_q   <= lfsr_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with WIDTH=4, PRESCALE_BITS=2, DEBOUNCE_BITS=2.
// Edge numbers count rising clk edges after reset release; outputs are sampled
// 1 time unit after the edge.
module tb_led_pattern_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;

    led_pattern_gen_if #(.WIDTH(4)) bus ();

    led_pattern_gen #(
        .WIDTH(4),
        .PRESCALE_BITS(2),
        .DEBOUNCE_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int e          = 0;

    localparam logic [3:0] GRAY_TAB   [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    localparam logic [3:0] LFSR_TAB   [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                              4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                              4'b0011};
    localparam logic [3:0] BOUNCE_TAB [8] = '{4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010,
                                              4'b0100, 4'b1000};
    localparam logic [1:0] PRESS_TAB  [3] = '{2'd2, 2'd3, 2'd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic adv_to(input int target);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    // Asserts reset between edges, checks outputs cleared at once, releases before next edge.
    task automatic reset_pulse(input logic btn_during);
        #2 rst = 1'b1;
        #1;
        check("rst_led",  32'(bus.led),  32'h0);
        check("rst_mode", 32'(bus.mode), 32'h0);
        check("rst_tick", 32'(bus.tick), 32'h0);
        bus.btn = btn_during;
        #2 rst = 1'b0;
        e = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bus.btn = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("init_led",  32'(bus.led),  32'h0);
        check("init_mode", 32'(bus.mode), 32'h0);
        check("init_tick", 32'(bus.tick), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        e = 0;

        // Binary count with tick cadence; wraps to 0 after 16 advances.
        adv_to(3);
        check("tick_pre", 32'(bus.tick), 32'h0);
        for (int a = 1; a <= 16; a++) begin
            adv_to(4 * a);
            check("tick_hi", 32'(bus.tick), 32'h1);
            adv_to(4 * a + 1);
            check("tick_lo", 32'(bus.tick), 32'h0);
            adv_to(4 * a + 2);
            check("binary", 32'(bus.led), 32'(a % 16));
        end

        // Short pulse rejected.
        bus.btn = 1'b1;
        adv_to(69);
        bus.btn = 1'b0;
        adv_to(80);
        check("glitch_mode", 32'(bus.mode), 32'h0);

        // Held press: btn seen at edge 81, mode increments at edge 86.
        bus.btn = 1'b1;
        adv_to(85);
        check("press_early", 32'(bus.mode), 32'h0);
        adv_to(86);
        check("press_mode", 32'(bus.mode), 32'h1);
        adv_to(87);
        check("press_gray", 32'(bus.led), 32'(4'b0111));
        adv_to(186);
        check("hold_mode", 32'(bus.mode), 32'h1);
        bus.btn = 1'b0;
        adv_to(196);
        check("release_mode", 32'(bus.mode), 32'h1);

        for (int p = 0; p < 3; p++) begin
            bus.btn = 1'b1;
            adv_to(e + 8);
            bus.btn = 1'b0;
            adv_to(e + 8);
            check("press_seq", 32'(bus.mode), 32'(PRESS_TAB[p]));
        end

        // Gray: select mode 1 right after reset, then watch steps 16..21 (0..5).
        reset_pulse(1'b1);
        adv_to(5);
        check("gray_sel_early", 32'(bus.mode), 32'h0);
        adv_to(6);
        check("gray_sel", 32'(bus.mode), 32'h1);
        bus.btn = 1'b0;
        for (int a = 16; a <= 21; a++) begin
            adv_to(4 * a + 2);
            check("gray", 32'(bus.led), 32'(GRAY_TAB[a - 16]));
        end

        // LFSR: two presses, then advances 5..17.
        reset_pulse(1'b1);
        adv_to(6);
        bus.btn = 1'b0;
        adv_to(12);
        bus.btn = 1'b1;
        adv_to(17);
        check("lfsr_sel_early", 32'(bus.mode), 32'h1);
        adv_to(18);
        check("lfsr_sel", 32'(bus.mode), 32'h2);
        bus.btn = 1'b0;
        for (int a = 5; a <= 17; a++) begin
            adv_to(4 * a + 2);
            check("lfsr", 32'(bus.led), 32'(LFSR_TAB[a - 5]));
        end

        // Bounce: three presses, then advances 8..15 covering both end bits.
        reset_pulse(1'b1);
        adv_to(6);
        bus.btn = 1'b0;
        adv_to(12);
        bus.btn = 1'b1;
        adv_to(18);
        check("bounce_mode2", 32'(bus.mode), 32'h2);
        bus.btn = 1'b0;
        adv_to(24);
        bus.btn = 1'b1;
        adv_to(29);
        check("bounce_sel_early", 32'(bus.mode), 32'h2);
        adv_to(30);
        check("bounce_sel", 32'(bus.mode), 32'h3);
        bus.btn = 1'b0;
        for (int a = 8; a <= 15; a++) begin
            adv_to(4 * a + 2);
            check("bounce", 32'(bus.led), 32'(BOUNCE_TAB[a - 8]));
        end

        // Reset mid-run while tick is high and mode is 3, then resume.
        adv_to(64);
        check("pre_rst_tick", 32'(bus.tick), 32'h1);
        check("pre_rst_mode", 32'(bus.mode), 32'h3);
        reset_pulse(1'b0);
        adv_to(3);
        check("post_tick3", 32'(bus.tick), 32'h0);
        adv_to(4);
        check("post_tick4", 32'(bus.tick), 32'h1);
        adv_to(5);
        check("post_tick5", 32'(bus.tick), 32'h0);
        adv_to(6);
        check("post_led", 32'(bus.led), 32'h1);
        adv_to(8);
        check("post_tick8", 32'(bus.tick), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
